// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequencer for a block-RAM delay line built on an external
// simple-dual-port RAM with a 1-cycle registered read. It zero-fills the RAM
// after reset or reconfiguration. After that, each accepted sample is written
// at wptr, and the word written D samples earlier is read back in the same cycle.
module delay_line_ctrl #(
   parameter int DATA_WIDTH    = 25,
   parameter int LEN           = 512,
   parameter int DEFAULT_DELAY = 16,
   localparam int AW           = $clog2(LEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AW-1:0]         cfg_delay,
   input  logic                  cfg_load,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_primed,
   output logic                  busy,
   output logic                  ram_wren,
   output logic [AW-1:0]         ram_wraddr,
   output logic [DATA_WIDTH-1:0] ram_wrdata,
   output logic                  ram_rden,
   output logic [AW-1:0]         ram_rdaddr,
   input  logic [DATA_WIDTH-1:0] ram_rddata
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam int            DEF_D = (DEFAULT_DELAY < 1)     ? 1 :
                                     (DEFAULT_DELAY > LEN-1) ? LEN-1 : DEFAULT_DELAY;
   localparam logic [AW-1:0] LAST  = AW'(LEN-1);
   localparam logic [AW-1:0] ONE   = AW'(1);
   localparam logic [AW:0]   LEN_X = (AW+1)'(LEN);

   state_t        state, state_nx;
   logic [AW-1:0] clr_cnt, wptr, fill_cnt, dly, cfg_d, rd_addr;
   logic [AW:0]   rd_wrap;
   logic          accept;

   // Clamp the requested delay into 1..LEN-1 so read and write never collide
   always_comb begin
      cfg_d = cfg_delay;
      if (cfg_delay == '0)
         cfg_d = ONE;
      else if ({1'b0, cfg_delay} >= LEN_X)
         cfg_d = LAST;
   end

   // Read pointer trails wptr by D words, with a modulo-LEN wrap for non power-of-two depths
   always_comb begin
      rd_wrap = {1'b0, wptr} + LEN_X - {1'b0, dly};
      if (wptr >= dly)
         rd_addr = wptr - dly;
      else
         rd_addr = rd_wrap[AW-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= CLEAR;
      else
         state <= state_nx;
   end

   // Next state: a reconfiguration always restarts the clear, which ends after the last word
   always_comb begin
      state_nx = state;
      if (cfg_load)
         state_nx = CLEAR;
      else if (state == CLEAR && clr_cnt == LAST)
         state_nx = RUN;
   end

   // Outputs: the clear sweep owns the write port; in RUN each accept writes and reads one word
   always_comb begin
      busy       = (state == CLEAR);
      in_ready   = (state == RUN);
      accept     = (state == RUN) && in_valid && !cfg_load;
      ram_wren   = 1'b0;
      ram_wraddr = '0;
      ram_wrdata = '0;
      ram_rden   = 1'b0;
      ram_rdaddr = '0;
      if (rst_n) begin
         if (state == CLEAR) begin
            ram_wren   = 1'b1;
            ram_wraddr = clr_cnt;
         end else if (accept) begin
            ram_wren   = 1'b1;
            ram_wraddr = wptr;
            ram_wrdata = in_data;
            ram_rden   = 1'b1;
            ram_rdaddr = rd_addr;
         end
      end
   end

   // Datapath registers: clear counter, write pointer, fill tracking and output strobe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_cnt    <= '0;
         wptr       <= '0;
         fill_cnt   <= '0;
         dly        <= AW'(DEF_D);
         out_valid  <= 1'b0;
         out_primed <= 1'b0;
      end else begin
         out_valid <= accept;
         if (cfg_load) begin
            dly        <= cfg_d;
            clr_cnt    <= '0;
            wptr       <= '0;
            fill_cnt   <= '0;
            out_primed <= 1'b0;
         end else if (state == CLEAR) begin
            if (clr_cnt == LAST) begin
               clr_cnt    <= '0;
               wptr       <= '0;
               fill_cnt   <= '0;
               out_primed <= 1'b0;
            end else begin
               clr_cnt <= clr_cnt + ONE;
            end
         end else if (accept) begin
            wptr <= (wptr == LAST) ? '0 : wptr + ONE;
            if (fill_cnt != dly)
               fill_cnt <= fill_cnt + ONE;
            // The D-th accept after a clear primes the output
            if (fill_cnt >= dly - ONE)
               out_primed <= 1'b1;
         end
      end
   end

   // Read data is only meaningful in the cycle after a read
   assign out_data = out_valid ? ram_rddata : '0;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl with LEN=10 and DEFAULT_DELAY=3, plus a behavioural RAM.
// Expected outputs are queued when a sample is accepted and popped when out_valid fires.
module tb_delay_line_ctrl;
   localparam int DW  = 25;
   localparam int LEN = 10;
   localparam int DEF = 3;
   localparam int AW  = $clog2(LEN);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] cfg_delay = '0;
   logic          cfg_load = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid, out_primed, busy;
   logic [DW-1:0] out_data;
   logic          ram_wren, ram_rden;
   logic [AW-1:0] ram_wraddr, ram_rdaddr;
   logic [DW-1:0] ram_wrdata;
   logic [DW-1:0] ram_rddata = '0;
   logic [DW-1:0] mem [0:LEN-1];

   delay_line_ctrl #(.DATA_WIDTH(DW), .LEN(LEN), .DEFAULT_DELAY(DEF)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .cfg_load(cfg_load),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_primed(out_primed), .busy(busy),
      .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
      .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata)
   );

   always #5 clk = ~clk;

   // Simple-dual-port RAM with registered read
   always @(posedge clk) begin
      if (ram_wren) mem[ram_wraddr] <= ram_wrdata;
      if (ram_rden) ram_rddata <= mem[ram_rdaddr];
   end

   typedef struct {
      logic [DW-1:0] data;
      int            idx;
      int            d;
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] hist[$];
   int            checks = 0;
   int            errs = 0;
   int            dq = DEF;
   int            clr_left = LEN;
   int            wp = 0;
   bit            prev_acc = 1'b0;
   bit            ov_known = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clampd(input int c);
      if (c == 0) return 1;
      if (c >= LEN) return LEN - 1;
      return c;
   endfunction

   // Output side of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("out_data", out_data, e.data);
            if (e.idx >= e.d)
               chk("out_primed_hi", out_primed, 32'd1);
            else if (e.idx < e.d - 1)
               chk("out_primed_lo", out_primed, 32'd0);
         end
      end
   end

   // One clock of stimulus with the model's view of that cycle checked before and after the edge
   task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d, input bit ld, input int cd);
      bit acc;
      int n, ra;
      if (ov_known) chk("out_valid", out_valid, prev_acc);
      rst_n = r; in_valid = v; in_data = d; cfg_load = ld; cfg_delay = AW'(cd);
      #1;
      acc = 1'b0;
      if (!r) begin
         chk("rst_ram_wren", ram_wren, 32'd0);
         chk("rst_ram_rden", ram_rden, 32'd0);
      end else if (ld) begin
         acc = 1'b0;
      end else if (clr_left > 0) begin
         chk("clr_busy", busy, 32'd1);
         chk("clr_in_ready", in_ready, 32'd0);
         chk("clr_wren", ram_wren, 32'd1);
         chk("clr_wraddr", ram_wraddr, LEN - clr_left);
         chk("clr_wrdata", ram_wrdata, 32'd0);
         chk("clr_rden", ram_rden, 32'd0);
      end else begin
         chk("run_in_ready", in_ready, 32'd1);
         chk("run_busy", busy, 32'd0);
         if (v) begin
            acc = 1'b1;
            ra = (wp >= dq) ? wp - dq : wp + LEN - dq;
            chk("run_wren", ram_wren, 32'd1);
            chk("run_wraddr", ram_wraddr, wp);
            chk("run_wrdata", ram_wrdata, d);
            chk("run_rden", ram_rden, 32'd1);
            chk("run_rdaddr", ram_rdaddr, ra);
            chk("no_collision", ram_rdaddr != ram_wraddr, 32'd1);
         end else begin
            chk("idle_wren", ram_wren, 32'd0);
            chk("idle_rden", ram_rden, 32'd0);
         end
      end
      @(posedge clk);
      ov_known = 1'b1;
      if (!r) begin
         dq = DEF; clr_left = LEN; wp = 0; hist.delete(); prev_acc = 1'b0;
      end else if (ld) begin
         dq = clampd(cd); clr_left = LEN; wp = 0; hist.delete(); prev_acc = 1'b0;
      end else if (clr_left > 0) begin
         clr_left--; prev_acc = 1'b0;
      end else if (acc) begin
         n = hist.size();
         sbq.push_back('{data: (n < dq) ? '0 : hist[n-dq], idx: n, d: dq});
         hist.push_back(d);
         wp = (wp == LEN - 1) ? 0 : wp + 1;
         prev_acc = 1'b1;
      end else begin
         prev_acc = 1'b0;
      end
      #1;
      if (!r) begin
         chk("rst_out_valid", out_valid, 32'd0);
         chk("rst_out_data", out_data, 32'd0);
         chk("rst_out_primed", out_primed, 32'd0);
         chk("rst_busy", busy, 32'd1);
         chk("rst_in_ready", in_ready, 32'd0);
      end
   endtask

   task automatic clear_phase();
      for (int i = 0; i < LEN; i++) cyc(1, 1'($urandom_range(0, 1)), DW'(500 + i), 0, 0);
   endtask

   initial begin
      int n;
      bit v;
      // Reset, then the initial clear with in_valid toggling (ignored)
      repeat (2) cyc(0, 1, DW'(7), 0, 0);
      clear_phase();
      // Default D=3, continuous ramp
      for (int i = 1; i <= 12; i++) cyc(1, 1, DW'(i), 0, 0);
      // Reconfigure mid-RUN with a sample present: dropped, the in-flight output still emits
      cyc(1, 1, DW'(99), 1, 9);
      clear_phase();
      // D=9 with random gaps across the 9->0 wrap
      n = 0;
      for (int k = 0; k < 400 && n < 25; k++) begin
         v = ($urandom_range(0, 2) != 0) || (n == 24);
         if (v) n++;
         cyc(1, v, DW'(200 + n), 0, 0);
      end
      chk("random_accepts", n, 32'd25);
      // cfg_delay=0 clamps to D=1
      cyc(1, 1, DW'(98), 1, 0);
      clear_phase();
      for (int i = 0; i < 6; i++) cyc(1, 1, DW'(300 + i), 0, 0);
      // cfg_delay=15 clamps to D=9
      cyc(1, 1, DW'(97), 1, 15);
      clear_phase();
      for (int i = 0; i < 12; i++) cyc(1, 1, DW'(400 + i), 0, 0);
      // Reconfigure to D=5, then reset mid-clear: D returns to the default
      cyc(1, 0, DW'(96), 1, 5);
      for (int i = 0; i < 4; i++) cyc(1, 1'(i), DW'(600 + i), 0, 0);
      cyc(0, 1, DW'(95), 0, 0);
      clear_phase();
      for (int i = 0; i < 6; i++) cyc(1, 1, DW'(700 + i), 0, 0);
      repeat (3) cyc(1, 0, DW'(0), 0, 0);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule
